// File: rtl/rst_seq_ctrl_if.sv
// Signal bundle between the reset controller and its surroundings.
// The master drives the request inputs; the slave drives the resets and the cause.
interface rst_seq_ctrl_if #(
  parameter int NUM_SRC = 1,
  parameter int NUM_OUT = 2
);
  logic                 i_btn_n;
  logic [NUM_SRC-1:0]   i_src_req;
  logic                 i_wdt_kick;
  logic [NUM_OUT-1:0]   o_rst_n;
  logic                 o_busy;
  logic [NUM_SRC+2:0]   o_cause;

  modport master (
    output i_btn_n, i_src_req, i_wdt_kick,
    input  o_rst_n, o_busy, o_cause
  );

  modport slave (
    input  i_btn_n, i_src_req, i_wdt_kick,
    output o_rst_n, o_busy, o_cause
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// System reset sequencer: power-on, debounced button and request merge.
// Optional watchdog request is built only when WDT_EN is defined.
module rst_seq_ctrl #(
  parameter int NUM_SRC    = 1,
  parameter int NUM_OUT    = 2,
  parameter int PO_WIDTH   = 1000,
  parameter int DEB_CYCLES = 100000,
  parameter int STRETCH    = 16,
  parameter int STAGGER    = 8,
  parameter int WDT_CYCLES = 50000000
) (
  input logic           i_clk,
  input logic           i_rst,
  rst_seq_ctrl_if.slave bus
);
  localparam int CW = NUM_SRC + 3;
  localparam int REL_LAST =
    (NUM_OUT > 1) ? (NUM_OUT - 1) * STAGGER - 1 : 0;
  localparam int PW = (PO_WIDTH < 1) ? 1 : $clog2(PO_WIDTH + 1);
  localparam int DW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam int SW = (STRETCH < 1) ? 1 : $clog2(STRETCH + 1);
  localparam int RW = (REL_LAST < 1) ? 1 : $clog2(REL_LAST + 1);

  typedef enum logic [1:0] {
    POR, HOLD, RELEASE, RUN
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   por_q, por_d;
  logic [SW-1:0]   str_q, str_d;
  logic [RW-1:0]   rel_q, rel_d;
  logic [1:0]      sync_q;
  logic            deb_q, deb_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [CW-1:0]   cause_q, cause_d;
  logic [CW-1:0]   req_bits;
  logic            req;
  logic            wdt_to;
  logic [NUM_OUT-1:0] rst_n;

`ifdef WDT_EN
  localparam int WW = (WDT_CYCLES < 1) ? 1 : $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d = wdt_q;
    if (state_q != RUN || bus.i_wdt_kick) wdt_d = '0;
    else if (wdt_q != WW'(WDT_CYCLES)) wdt_d = wdt_q + WW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) wdt_q <= '0;
    else       wdt_q <= wdt_d;
  end

  assign wdt_to = (state_q == RUN) && (wdt_q == WW'(WDT_CYCLES));
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  wire unused_kick = bus.i_wdt_kick;
  assign wdt_to = 1'b0;
`endif

  assign req_bits = {wdt_to, bus.i_src_req, ~deb_q, 1'b0};
  assign req      = |req_bits;

  // Debounced level flips only after an unbroken run of disagreement.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (dcnt_q == DW'(DEB_CYCLES - 1)) deb_d = ~deb_q;
      else dcnt_d = dcnt_q + DW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= POR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      POR:
        if (por_q == PW'(PO_WIDTH - 1)) state_d = HOLD;
      HOLD:
        if (!req && str_q == SW'(STRETCH)) state_d = RELEASE;
      RELEASE:
        if (req) state_d = HOLD;
        else if (rel_q == RW'(REL_LAST)) state_d = RUN;
      RUN:
        if (req) state_d = HOLD;
      default: state_d = POR;
    endcase
  end

  always_comb begin
    por_d = por_q;
    if (state_q == POR && por_q != PW'(PO_WIDTH))
      por_d = por_q + PW'(1);

    str_d = '0;
    if (state_q == HOLD && !req)
      str_d = (str_q == SW'(STRETCH)) ? str_q : str_q + SW'(1);

    rel_d = '0;
    if (state_q == RELEASE && rel_q != RW'(REL_LAST))
      rel_d = rel_q + RW'(1);

    // A new request after release restarts the cause record.
    cause_d = cause_q | req_bits;
    if (state_q == RELEASE || state_q == RUN)
      cause_d = req ? req_bits : cause_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      por_q   <= '0;
      str_q   <= '0;
      rel_q   <= '0;
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      dcnt_q  <= '0;
      cause_q <= CW'(1);
    end else begin
      por_q   <= por_d;
      str_q   <= str_d;
      rel_q   <= rel_d;
      sync_q  <= {sync_q[0], bus.i_btn_n};
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    rst_n = '0;
    for (int k = 0; k < NUM_OUT; k++)
      rst_n[k] = (state_q == RUN) ||
                 (state_q == RELEASE && int'(rel_q) >= k * STAGGER);
  end

  assign bus.o_rst_n = rst_n;
  assign bus.o_busy  = (state_q != RUN);
  assign bus.o_cause = cause_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios then random requests,
// compared each cycle against an event-time reference model.
module tb_rst_seq_ctrl;
  localparam int NS  = 1;
  localparam int NO  = 3;
  localparam int PO  = 10;
  localparam int DEB = 4;
  localparam int ST  = 5;
  localparam int SG  = 3;
  localparam int WD  = 20;
  localparam int CW  = NS + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.NUM_SRC(NS), .NUM_OUT(NO)) bus();

  rst_seq_ctrl #(
    .NUM_SRC(NS), .NUM_OUT(NO), .PO_WIDTH(PO), .DEB_CYCLES(DEB),
    .STRETCH(ST), .STAGGER(SG), .WDT_CYCLES(WD)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  bit auto_kick = 1'b1;

  // Model: e = edges since reset release, rel_at = edge where out 0 rises.
  int            e;
  int            rel_at;
  int            idle;
  logic [CW-1:0] cause_m;
  bit            deb_m;
  bit            hist[$];

  function automatic int run_at();
    return rel_at + ((NO > 1) ? (NO - 1) * SG : 1);
  endfunction

  task automatic model_edge();
    bit            to;
    bit            all_diff;
    bit            run_before;
    logic [CW-1:0] bits;
    if (rst) begin
      e = 0;
      rel_at = PO + ST + 1;
      cause_m = CW'(1);
      deb_m = 1'b1;
      idle = 0;
      hist.delete();
      repeat (DEB + 2) hist.push_back(1'b1);
      return;
    end
    e++;
    to = 1'b0;
    run_before = (e - 1) >= run_at();
`ifdef WDT_EN
    to = run_before && (idle == WD);
    if (!run_before || bus.i_wdt_kick) idle = 0;
    else if (idle < WD) idle++;
`endif
    bits = {to, bus.i_src_req, ~deb_m, 1'b0};
    if (|bits) begin
      if (e > rel_at) begin
        rel_at = e + ST + 1;
        cause_m = bits;
      end else begin
        if (e + ST + 1 > rel_at) rel_at = e + ST + 1;
        cause_m = cause_m | bits;
      end
    end
    all_diff = 1'b1;
    for (int j = 1; j <= DEB; j++)
      if (hist[hist.size() - 1 - j] == deb_m) all_diff = 1'b0;
    if (all_diff) deb_m = ~deb_m;
    hist.push_back(bus.i_btn_n);
    void'(hist.pop_front());
  endtask

  task automatic check_model();
    logic [NO-1:0] er;
    logic          eb;
    for (int k = 0; k < NO; k++) er[k] = (e >= rel_at + k * SG);
    eb = (e < run_at());
    checks++;
    assert (bus.o_rst_n === er) else begin
      errors++;
      $error("FAIL model_rst_n e=%0d got=%b exp=%b", e, bus.o_rst_n, er);
    end
    checks++;
    assert (bus.o_busy === eb) else begin
      errors++;
      $error("FAIL model_busy e=%0d got=%b exp=%b", e, bus.o_busy, eb);
    end
    checks++;
    assert (bus.o_cause === cause_m) else begin
      errors++;
      $error("FAIL model_cause e=%0d got=%h exp=%h", e, bus.o_cause, cause_m);
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    ncyc++;
    if (auto_kick) bus.i_wdt_kick = (ncyc % 10 == 0);
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic wait_run();
    for (int i = 0; i < 100 && bus.o_busy !== 1'b0; i++) tick();
    chk("run_reached", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic wait_rel0();
    for (int i = 0; i < 60 && bus.o_rst_n !== 3'b001; i++) tick();
    chk("rel0_reached", 32'(bus.o_rst_n), 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_btn_n = 1'b1;
    bus.i_src_req = '0;
    bus.i_wdt_kick = 1'b0;

    // Power-up
    repeat (3) tick();
    chk("rst_rstn", 32'(bus.o_rst_n), 32'h0);
    chk("rst_cause", 32'(bus.o_cause), 32'h1);
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 15) chk("pu_c15", 32'(bus.o_rst_n), 32'h0);
      if (i == 16) chk("pu_c16", 32'(bus.o_rst_n), 32'h1);
      if (i == 19) chk("pu_c19", 32'(bus.o_rst_n), 32'h3);
      if (i == 21) chk("pu_busy21", 32'(bus.o_busy), 32'h1);
      if (i == 22) chk("pu_c22", 32'(bus.o_rst_n), 32'h7);
      if (i == 22) chk("pu_busy22", 32'(bus.o_busy), 32'h0);
    end
    chk("pu_cause", 32'(bus.o_cause), 32'h1);

    // Button glitch, then a held press
    bus.i_btn_n = 1'b0;
    repeat (3) tick();
    bus.i_btn_n = 1'b1;
    repeat (10) tick();
    chk("glitch_busy", 32'(bus.o_busy), 32'h0);
    bus.i_btn_n = 1'b0;
    repeat (6) tick();
    chk("btn_pre", 32'(bus.o_rst_n), 32'h7);
    tick();
    chk("btn_rstn", 32'(bus.o_rst_n), 32'h0);
    chk("btn_cause", 32'(bus.o_cause), 32'h2);
    repeat (3) tick();
    bus.i_btn_n = 1'b1;
    wait_run();

    // Request during RELEASE
    bus.i_src_req = 1'b1;
    tick();
    bus.i_src_req = 1'b0;
    wait_rel0();
    bus.i_src_req = 1'b1;
    tick();
    bus.i_src_req = 1'b0;
    chk("relreq_rstn", 32'(bus.o_rst_n), 32'h0);
    chk("relreq_cause", 32'(bus.o_cause), 32'h4);
    wait_run();

    // Simultaneous sources, then an added source in HOLD
    bus.i_btn_n = 1'b0;
    repeat (6) tick();
    bus.i_src_req = 1'b1;
    tick();
    bus.i_src_req = 1'b0;
    chk("both_cause", 32'(bus.o_cause), 32'h6);
    bus.i_btn_n = 1'b1;
    wait_run();
    bus.i_btn_n = 1'b0;
    repeat (7) tick();
    chk("hold_cause_a", 32'(bus.o_cause), 32'h2);
    bus.i_src_req = 1'b1;
    tick();
    bus.i_src_req = 1'b0;
    chk("hold_cause_b", 32'(bus.o_cause), 32'h6);
    bus.i_btn_n = 1'b1;
    wait_run();

    // Reset in the middle of RELEASE
    bus.i_src_req = 1'b1;
    tick();
    bus.i_src_req = 1'b0;
    wait_rel0();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rstn", 32'(bus.o_rst_n), 32'h0);
    chk("mid_cause", 32'(bus.o_cause), 32'h1);
    repeat (16) tick();
    chk("mid_rel16", 32'(bus.o_rst_n), 32'h1);
    wait_run();

    // Watchdog
    auto_kick = 1'b0;
    bus.i_wdt_kick = 1'b0;
`ifdef WDT_EN
    repeat (25) tick();
    chk("wdt_cause", 32'(bus.o_cause), 32'h8);
    auto_kick = 1'b1;
    wait_run();
    repeat (200) tick();
    chk("wdt_kept", 32'(bus.o_busy), 32'h0);
`else
    repeat (40) tick();
    chk("nowdt_busy", 32'(bus.o_busy), 32'h0);
    chk("nowdt_cause", 32'(bus.o_cause[CW-1]), 32'h0);
`endif

    // Random requests
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.i_btn_n = ~bus.i_btn_n;
      bus.i_src_req = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 599) == 0);
      auto_kick = ($urandom_range(0, 99) != 0);
      if (!auto_kick) bus.i_wdt_kick = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
